// File: rtl/regfile_dump_ctrl.sv
// Debug-unit sequencer: stalls the pipeline and streams every register-file word
// out as bytes (MSB byte first) over a valid/ready handshake.
module regfile_dump_ctrl #(
   parameter int NB_REG  = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_stall,
   output logic               o_done,
   output logic [NB_ADDR-1:0] o_rf_addr,
   input  logic [NB_REG-1:0]  i_rf_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready
);

   localparam int NUM_BYTES = NB_REG / NB_BYTE;
   localparam int NB_CNT    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(NUM_BYTES - 1);
   localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [NB_REG-1:0]  shift_reg;
   logic [NB_CNT-1:0]  byte_cnt;
   logic [NB_ADDR-1:0] rf_addr;
   logic               tx_valid;
   logic               accept;
   logic               last_byte;
   logic               last_addr;

   assign accept    = tx_valid & i_tx_ready;
   assign last_byte = (byte_cnt == LAST_BYTE);
   assign last_addr = (rf_addr == LAST_ADDR);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            next_state = SEND;
         end
         SEND: begin
            if (accept && last_byte) begin
               next_state = last_addr ? DONE : LOAD;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      o_busy  = (state != IDLE);
      o_stall = (state != IDLE);
      o_done  = (state == DONE);
   end

   // The address only advances between registers; at the last address it holds
   // so the DONE cycle still reports the final register before returning to 0.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         shift_reg <= '0;
         byte_cnt  <= '0;
         rf_addr   <= '0;
         tx_valid  <= 1'b0;
      end else begin
         tx_valid <= (next_state == SEND);
         unique case (state)
            IDLE: begin
               rf_addr <= '0;
            end
            LOAD: begin
               shift_reg <= i_rf_data;
               byte_cnt  <= '0;
            end
            SEND: begin
               if (accept) begin
                  shift_reg <= shift_reg << NB_BYTE;
                  byte_cnt  <= byte_cnt + NB_CNT'(1);
                  if (last_byte && !last_addr) begin
                     rf_addr <= rf_addr + NB_ADDR'(1);
                  end
               end
            end
            DONE: begin
               rf_addr <= '0;
            end
            default: begin
               rf_addr <= '0;
            end
         endcase
      end
   end

   assign o_rf_addr  = rf_addr;
   assign o_tx_valid = tx_valid;
   assign o_tx_data  = shift_reg[NB_REG-1 -: NB_BYTE];

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: stimulus pushes expected bytes and done
// pulses into queues, a negedge monitor pops and compares them as the DUT emits.
module tb_regfile_dump_ctrl;

   localparam int NUM_REGS    = 32;
   localparam int DUMP_CYCLES = 161;

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy;
   logic        stall;
   logic        done;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic [31:0] rf_mem [NUM_REGS];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] sb_q [$];
   int         done_q [$];

   int done_seen       = 0;
   int acc_cnt         = 0;
   int first_valid_cyc = -1;
   int start_cyc       = 0;
   int busy_cnt        = 0;
   int stall_mismatch  = 0;
   int ready_mode      = 0;
   int stall_left      = 0;
   bit stall_fired     = 0;
   bit prev_held       = 0;

   regfile_dump_ctrl #(
      .NB_REG (32),
      .NB_ADDR(5),
      .NB_BYTE(8)
   ) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_start   (start),
      .o_busy    (busy),
      .o_stall   (stall),
      .o_done    (done),
      .o_rf_addr (rf_addr),
      .i_rf_data (rf_data),
      .o_tx_data (tx_data),
      .o_tx_valid(tx_valid),
      .i_tx_ready(tx_ready)
   );

   assign rf_data = rf_mem[rf_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [31:0] patWord(input int pat, input int k);
      logic [7:0] kb;
      kb = 8'(k);
      case (pat)
         0:       return 32'hA500_0000 + 32'(k);
         1:       return {8'hA5, kb + 8'h40, kb ^ 8'h5A, kb};
         default: return {~kb, 8'h3C, kb + 8'h01, kb ^ 8'hC3};
      endcase
   endfunction

   task automatic loadPattern(input int pat);
      for (int k = 0; k < NUM_REGS; k++) rf_mem[k] = patWord(pat, k);
   endtask

   task automatic pushDump(input int pat, input int exp_done);
      logic [31:0] w;
      for (int k = 0; k < NUM_REGS; k++) begin
         w = patWord(pat, k);
         for (int b = 3; b >= 0; b--) sb_q.push_back(w[b*8 +: 8]);
      end
      done_q.push_back(exp_done);
   endtask

   // Called at posedge+1; pulses start for one cycle.
   task automatic applyStimulus(input int pat, input bit timed);
      loadPattern(pat);
      pushDump(pat, timed ? cyc + DUMP_CYCLES : -1);
      acc_cnt         = 0;
      first_valid_cyc = -1;
      busy_cnt        = 0;
      start_cyc       = cyc;
      start           = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (done_seen < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput(name, done_seen, target);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Ready driver: 0 = always ready, 1 = random, 2 = one 3-cycle stall on byte 30 (reg 7, byte 2).
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = 1'($urandom_range(0, 1));
         default: begin
            if (stall_left > 0) begin
               tx_ready = 1'b0;
               stall_left--;
            end else if (!stall_fired && acc_cnt == 30 && tx_valid === 1'b1) begin
               tx_ready    = 1'b0;
               stall_left  = 2;
               stall_fired = 1'b1;
            end else begin
               tx_ready = 1'b1;
            end
         end
      endcase
   end

   // Monitor: compares every accepted byte and every done pulse against the queues.
   always @(negedge clk) begin
      if (!reset) begin
         if (stall !== busy) stall_mismatch++;
         if (busy === 1'b1) busy_cnt++;
         if (prev_held) checkOutput("tx_valid_held", {31'b0, tx_valid}, 32'd1);
         prev_held = 1'b0;
         if (tx_valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_byte: got %0h, expected no valid (cycle %0d)", tx_data, cyc);
            end else if (tx_ready === 1'b1) begin
               checkOutput("tx_byte", {24'b0, tx_data}, {24'b0, sb_q.pop_front()});
               acc_cnt++;
            end else begin
               checkOutput("tx_hold", {24'b0, tx_data}, {24'b0, sb_q[0]});
               prev_held = 1'b1;
            end
         end
         if (done === 1'b1) begin
            int e;
            done_seen++;
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got pulse, expected none (cycle %0d)", cyc);
            end else begin
               e = done_q.pop_front();
               if (e >= 0) checkOutput("done_cycle", cyc, e);
               checkOutput("done_rf_addr", {27'b0, rf_addr}, 32'd31);
            end
         end
      end else begin
         prev_held = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset    = 1'b1;
      start    = 1'b0;
      tx_ready = 1'b1;
      loadPattern(0);

      // T1: reset
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t1_busy",    {31'b0, busy},     32'd0);
      checkOutput("t1_stall",   {31'b0, stall},    32'd0);
      checkOutput("t1_done",    {31'b0, done},     32'd0);
      checkOutput("t1_valid",   {31'b0, tx_valid}, 32'd0);
      checkOutput("t1_rf_addr", {27'b0, rf_addr},  32'd0);
      checkOutput("t1_tx_data", {24'b0, tx_data},  32'd0);
      reset = 1'b0;
      idleCycles(2);

      // T2: full dump with ready tied high
      $display("[TB] T2 full dump");
      applyStimulus(0, 1'b1);
      waitDone(1, 400, "t2_done_seen");
      idleCycles(2);
      checkOutput("t2_first_valid_latency", first_valid_cyc - start_cyc, 32'd2);
      checkOutput("t2_busy_cycles", busy_cnt, DUMP_CYCLES);
      checkOutput("t2_bytes_accepted", acc_cnt, 32'd128);
      checkOutput("t2_rf_addr_idle", {27'b0, rf_addr}, 32'd0);
      checkOutput("t2_queue_empty", sb_q.size(), 32'd0);

      // T3: backpressure on reg 7 byte 2
      $display("[TB] T3 backpressure");
      ready_mode  = 2;
      stall_fired = 1'b0;
      applyStimulus(1, 1'b0);
      waitDone(2, 400, "t3_done_seen");
      ready_mode = 0;
      idleCycles(2);
      checkOutput("t3_stall_fired", {31'b0, stall_fired}, 32'd1);
      checkOutput("t3_bytes_accepted", acc_cnt, 32'd128);
      checkOutput("t3_queue_empty", sb_q.size(), 32'd0);

      // T4: start pulse while busy is ignored
      $display("[TB] T4 start while busy");
      applyStimulus(0, 1'b1);
      idleCycles(50);
      start = 1'b1;
      idleCycles(1);
      start = 1'b0;
      waitDone(3, 400, "t4_done_seen");
      idleCycles(10);
      checkOutput("t4_busy_after", {31'b0, busy}, 32'd0);
      checkOutput("t4_done_count", done_seen, 32'd3);
      checkOutput("t4_queue_empty", sb_q.size(), 32'd0);

      // T5: reset mid-dump at reg 12, then a fresh dump from reg 0
      $display("[TB] T5 reset mid-dump");
      applyStimulus(0, 1'b0);
      n = 0;
      while (rf_addr !== 5'd12 && n < 200) begin
         idleCycles(1);
         n++;
      end
      checkOutput("t5_reached_reg12", {27'b0, rf_addr}, 32'd12);
      reset = 1'b1;
      idleCycles(1);
      reset = 1'b0;
      sb_q.delete();
      done_q.delete();
      checkOutput("t5_valid_after_reset", {31'b0, tx_valid}, 32'd0);
      checkOutput("t5_busy_after_reset",  {31'b0, busy},     32'd0);
      checkOutput("t5_rf_addr_after_reset", {27'b0, rf_addr}, 32'd0);
      idleCycles(5);
      checkOutput("t5_no_done", done_seen, 32'd3);
      applyStimulus(0, 1'b1);
      waitDone(4, 400, "t5_done_seen");
      idleCycles(2);
      checkOutput("t5_queue_empty", sb_q.size(), 32'd0);

      // T6: random ready, three back-to-back dumps with start held high
      $display("[TB] T6 random ready back-to-back");
      ready_mode = 1;
      loadPattern(2);
      for (int d = 0; d < 3; d++) pushDump(2, -1);
      acc_cnt = 0;
      start   = 1'b1;
      waitDone(7, 5000, "t6_done_seen");
      start      = 1'b0;
      ready_mode = 0;
      idleCycles(10);
      checkOutput("t6_bytes_accepted", acc_cnt, 32'd384);
      checkOutput("t6_busy_after", {31'b0, busy}, 32'd0);
      checkOutput("t6_queue_empty", sb_q.size(), 32'd0);
      checkOutput("t6_done_queue_empty", done_q.size(), 32'd0);

      checkOutput("stall_eq_busy_mismatches", stall_mismatch, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
